// File: rtl/run_checker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | run_checker: snoops the store bus until halt or timeout, then reads back |
// | NUM_CHECKS words and compares them. Option: RUN_CHECKER_STORE_LOG_EN.    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module run_checker #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int NUM_CHECKS = 4,
  parameter int TIMEOUT    = 1024,
  parameter int CNT_WIDTH  = 16,
  parameter logic [ADDR_WIDTH-1:0] HALT_ADDR = 32'hFFFF_FFFC
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             start,
  input  logic                             memWrite,
  input  logic [ADDR_WIDTH-1:0]            memAddr,
  input  logic [DATA_WIDTH-1:0]            memWriteData,
  input  logic [NUM_CHECKS*ADDR_WIDTH-1:0] checkAddr,
  input  logic [NUM_CHECKS*DATA_WIDTH-1:0] checkValue,
  output logic [ADDR_WIDTH-1:0]            rdAddr,
  input  logic [DATA_WIDTH-1:0]            rdData,
  output logic                             busy,
  output logic                             done,
  output logic                             pass,
  output logic                             timedOut,
  output logic [NUM_CHECKS-1:0]            failMask,
`ifdef RUN_CHECKER_STORE_LOG_EN
  output logic [CNT_WIDTH-1:0]             storeCount,
`endif
  output logic [CNT_WIDTH-1:0]             cycleCount
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_CHECK = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam int IDX_W = $clog2(NUM_CHECKS + 1);
  localparam logic [IDX_W-1:0]     LAST_IDX   = IDX_W'(NUM_CHECKS);
  localparam logic [CNT_WIDTH-1:0] TIMEOUT_M1 = CNT_WIDTH'(TIMEOUT - 1);

  logic [1:0]            state_q, state_d;
  logic [CNT_WIDTH-1:0]  cycle_q, cycle_d;
  logic [NUM_CHECKS-1:0] fail_q, fail_d;
  logic                  timed_q, timed_d;
  logic                  pass_q, pass_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;

  logic halt, timeout_hit, restart;
  logic unused_write_data;

  assign halt        = memWrite && (memAddr == HALT_ADDR);
  assign timeout_hit = (cycle_q == TIMEOUT_M1);
  assign restart     = start && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign unused_write_data = ^memWriteData;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cycle_q   <= '0;
      fail_q    <= '0;
      timed_q   <= 1'b0;
      pass_q    <= 1'b0;
      idx_q     <= '0;
      rd_addr_q <= '0;
    end else begin
      state_q   <= state_d;
      cycle_q   <= cycle_d;
      fail_q    <= fail_d;
      timed_q   <= timed_d;
      pass_q    <= pass_d;
      idx_q     <= idx_d;
      rd_addr_q <= rd_addr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: if (start) state_d = S_RUN;
      S_RUN:          if (halt || timeout_hit) state_d = S_CHECK;
      S_CHECK:        if (idx_q == LAST_IDX) state_d = S_DONE;
      default:        state_d = S_IDLE;
    endcase
  end

  // Read-back is pipelined: index k presents slot k+1's address and scores slot k-1.
  always_comb begin
    cycle_d   = cycle_q;
    fail_d    = fail_q;
    timed_d   = timed_q;
    pass_d    = pass_q;
    idx_d     = idx_q;
    rd_addr_d = '0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (restart) begin
          cycle_d = '0;
          fail_d  = '0;
          timed_d = 1'b0;
          pass_d  = 1'b0;
          idx_d   = '0;
        end
      end
      S_RUN: begin
        cycle_d = cycle_q + 1'b1;
        if (!halt && timeout_hit) timed_d = 1'b1;
        if (halt || timeout_hit) begin
          rd_addr_d = checkAddr[ADDR_WIDTH-1:0];
          idx_d     = '0;
        end
      end
      S_CHECK: begin
        idx_d = idx_q + 1'b1;
        for (int i = 1; i < NUM_CHECKS; i++) begin
          if (idx_q == IDX_W'(i - 1)) rd_addr_d = checkAddr[i*ADDR_WIDTH +: ADDR_WIDTH];
        end
        for (int i = 0; i < NUM_CHECKS; i++) begin
          if ((idx_q == IDX_W'(i + 1)) && (rdData != checkValue[i*DATA_WIDTH +: DATA_WIDTH]))
            fail_d[i] = 1'b1;
        end
        if (idx_q == LAST_IDX) pass_d = (fail_d == '0) && !timed_q;
      end
      default: ;
    endcase
  end

  always_comb begin
    busy = (state_q == S_RUN) || (state_q == S_CHECK);
    done = (state_q == S_DONE);
  end

  assign rdAddr     = rd_addr_q;
  assign pass       = pass_q;
  assign timedOut   = timed_q;
  assign failMask   = fail_q;
  assign cycleCount = cycle_q;

`ifdef RUN_CHECKER_STORE_LOG_EN
  logic [CNT_WIDTH-1:0] store_cnt_q, store_cnt_d;
  logic                 log_store;

  assign log_store = (state_q == S_RUN) && memWrite && !halt;

  always_comb begin
    store_cnt_d = store_cnt_q;
    if (restart) store_cnt_d = '0;
    else if (log_store) store_cnt_d = store_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) store_cnt_q <= '0;
    else        store_cnt_q <= store_cnt_d;
  end

  assign storeCount = store_cnt_q;

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (rst_n && log_store)
      $display("[run_checker] store cycle=%0d addr=%h data=%h", cycle_d, memAddr, memWriteData);
  end
`endif
`endif

endmodule
`default_nettype wire

// File: tb/tb_run_checker.sv
`default_nettype none
// Randomized bench for run_checker: a shadow memory and rule-level model
// predict cycleCount, timedOut, failMask, pass and the read-back address order.
module tb_run_checker;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int NC = 4;
  localparam int TO = 128;
  localparam int CW = 16;
  localparam logic [31:0] HALT = 32'hFFFF_FFFC;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              memWrite = 1'b0;
  logic [AW-1:0]     memAddr = '0;
  logic [DW-1:0]     memWriteData = '0;
  logic [NC*AW-1:0]  checkAddr = '0;
  logic [NC*DW-1:0]  checkValue = '0;
  logic [AW-1:0]     rdAddr;
  logic [DW-1:0]     rdData;
  logic              busy, done, pass, timedOut;
  logic [NC-1:0]     failMask;
  logic [CW-1:0]     cycleCount;
`ifdef RUN_CHECKER_STORE_LOG_EN
  logic [CW-1:0]     storeCount;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  logic [31:0] mem [256];
  logic [31:0] shadow [256];
  int          caddr [NC];
  logic [31:0] cval [NC];

  run_checker #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_CHECKS(NC),
    .TIMEOUT(TO), .CNT_WIDTH(CW), .HALT_ADDR(HALT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .memWrite(memWrite), .memAddr(memAddr), .memWriteData(memWriteData),
    .checkAddr(checkAddr), .checkValue(checkValue),
    .rdAddr(rdAddr), .rdData(rdData),
    .busy(busy), .done(done), .pass(pass), .timedOut(timedOut),
    .failMask(failMask),
`ifdef RUN_CHECKER_STORE_LOG_EN
    .storeCount(storeCount),
`endif
    .cycleCount(cycleCount)
  );

  always #5 clk = ~clk;

  // Data memory with one-cycle read latency.
  always @(posedge clk) begin
    if (memWrite && memAddr != HALT) mem[memAddr[9:2]] <= memWriteData;
    rdData <= mem[rdAddr[9:2]];
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic poke(input int idx, input logic [31:0] v);
    memWrite = 1'b1;
    memAddr = 32'(idx) << 2;
    memWriteData = v;
    shadow[idx] = v;
    @(negedge clk);
    memWrite = 1'b0;
  endtask

  // mode 0: random match per slot, 1: all match, 2: only slot 2 wrong, 3: accumulation setup
  task automatic prepare(input int mode);
    int base;
    bit good;
    base = $urandom_range(255);
    for (int i = 0; i < NC; i++) begin
      caddr[i] = (mode == 3) ? ((i == 0) ? 3 : 10 + i) : (base + 37 * i) % 256;
      cval[i] = (mode == 3 && i == 0) ? 32'd45 : $urandom;
      checkAddr[i*AW +: AW] = 32'(caddr[i]) << 2;
      checkValue[i*DW +: DW] = cval[i];
      case (mode)
        0: good = ($urandom_range(1) == 1);
        2: good = (i != 2);
        3: good = (i != 0);
        default: good = 1'b1;
      endcase
      poke(caddr[i], good ? cval[i] : ~cval[i]);
    end
  endtask

  task automatic run_case(input string name, input int halt_at, input bit rnd,
                          input int nfix, input bit sir, input bit acc);
    logic [NC-1:0] exp_mask;
    bit exp_to;
    int exp_cnt;
    int stores;
    int idx;
    stores = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({name, ".busy"}, {busy, done}, 2'b10);
`ifdef RUN_CHECKER_STORE_LOG_EN
    check({name, ".store_clr"}, storeCount, 0);
`endif
    for (int c = 1; c <= TO; c++) begin
      if (c == halt_at) begin
        memWrite = 1'b1; memAddr = HALT; memWriteData = 32'h600D;
      end else if (acc && c == 50) begin
        memWrite = 1'b1; memAddr = 32'd12; memWriteData = 32'd45;
        shadow[3] = 32'd45; stores++;
      end else if (c <= 2 * nfix && c % 2 == 0) begin
        idx = 200 + c / 2;
        memWrite = 1'b1; memAddr = 32'(idx) << 2; memWriteData = 32'(c);
        shadow[idx] = 32'(c); stores++;
      end else if (rnd && $urandom_range(3) == 0) begin
        idx = $urandom_range(255);
        memWrite = 1'b1; memAddr = 32'(idx) << 2; memWriteData = $urandom;
        shadow[idx] = memWriteData; stores++;
      end
      if (sir && c == 5) start = 1'b1;
      @(negedge clk);
      memWrite = 1'b0;
      start = 1'b0;
      if (c == halt_at) break;
    end
    exp_to = (halt_at < 1) || (halt_at > TO);
    exp_cnt = exp_to ? TO : halt_at;
    for (int i = 0; i < NC; i++) exp_mask[i] = (shadow[caddr[i]] != cval[i]);
    for (int k = 0; k <= NC; k++) begin
      check({name, ".rdaddr"}, rdAddr, (k < NC) ? (32'(caddr[k]) << 2) : 32'd0);
      check({name, ".chk_state"}, {busy, done}, 2'b10);
      @(negedge clk);
    end
    check({name, ".done"}, {busy, done}, 2'b01);
    check({name, ".timedOut"}, timedOut, exp_to);
    check({name, ".cycleCount"}, cycleCount, exp_cnt);
    check({name, ".failMask"}, failMask, exp_mask);
    check({name, ".pass"}, pass, (exp_mask == 0) && !exp_to);
`ifdef RUN_CHECKER_STORE_LOG_EN
    check({name, ".storeCount"}, storeCount, stores);
`endif
    @(negedge clk);
    check({name, ".hold"}, {done, pass, cycleCount}, {1'b1, (exp_mask == 0) && !exp_to, 16'(exp_cnt)});
  endtask

  function automatic logic [63:0] all_out();
    return {8'h0, busy, done, pass, timedOut, failMask, cycleCount, rdAddr};
  endfunction

  initial begin
    repeat (3) @(negedge clk);
    check("reset.outputs", all_out(), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle.outputs", all_out(), 0);

    prepare(3);
    run_case("accum", 100, 1'b0, 0, 1'b0, 1'b1);
    prepare(2);
    run_case("mismatch", 30, 1'b0, 0, 1'b0, 1'b0);
    prepare(1);
    run_case("timeout", 0, 1'b0, 0, 1'b0, 1'b0);
    prepare(0);
    run_case("simul", TO, 1'b1, 0, 1'b0, 1'b0);
    prepare(1);
    run_case("storelog", 40, 1'b0, 7, 1'b0, 1'b0);

    // Abort in the third CHECK cycle.
    prepare(1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    memWrite = 1'b1; memAddr = HALT;
    @(negedge clk);
    memWrite = 1'b0;
    repeat (2) @(negedge clk);
    check("abort.in_check", {busy, done}, 2'b10);
    rst_n = 1'b0;
    #1;
    check("abort.outputs", all_out(), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("abort.idle", all_out(), 0);

    prepare(1);
    run_case("restart", 25, 1'b1, 0, 1'b1, 1'b0);

    for (int r = 0; r < 6; r++) begin
      prepare(0);
      run_case("random", $urandom_range(TO + 20, 1), 1'b1, 0, r[0], 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
`default_nettype wire
